// File: rtl/square_wave_meter.sv
// square_wave_meter: measures each half-period of an asynchronous square wave and recovers the
// generator prescaler (half-period - 1). Define SQW_MATCH_EN to add the expected/match comparator.
module square_wave_meter #(
   parameter int CNT_W     = 16,
   parameter int TIMEOUT   = 65535,
   parameter int MATCH_TOL = 0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic             sig,
   output logic [CNT_W-1:0] prescaler_out,
   output logic [CNT_W:0]   period_out,
   output logic             level_high,
   output logic             meas_valid,
   output logic             timeout
`ifdef SQW_MATCH_EN
   ,
   input  logic [CNT_W-1:0] expected,
   output logic             match
`endif
);

   typedef enum logic [1:0] {IDLE = 2'd0, ARM = 2'd1, RUN = 2'd2} state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] TO_LIM  = CNT_W'(TIMEOUT);

   state_t           state;
   logic             s1, s2, s3;
   logic             sig_edge;
   logic [CNT_W-1:0] cnt, cnt_inc;
   logic [CNT_W-1:0] hi_cnt, lo_cnt, other_cnt;
   logic             hi_ok, lo_ok, other_ok;
   logic [CNT_W:0]   period_sum;

   // s3 is the level of the phase that the current edge terminates.
   assign sig_edge   = s2 ^ s3;
   assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
   assign other_cnt  = s3 ? lo_cnt : hi_cnt;
   assign other_ok   = s3 ? lo_ok : hi_ok;
   assign period_sum = {1'b0, cnt} + {1'b0, other_cnt} + (CNT_W+1)'(2);

`ifdef SQW_MATCH_EN
   localparam logic [CNT_W-1:0] TOL = CNT_W'(MATCH_TOL);
   logic [CNT_W-1:0] diff;
   logic             match_hit;
   assign diff      = (cnt >= expected) ? cnt - expected : expected - cnt;
   assign match_hit = (diff <= TOL);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         s1            <= 1'b0;
         s2            <= 1'b0;
         s3            <= 1'b0;
         cnt           <= '0;
         hi_cnt        <= '0;
         lo_cnt        <= '0;
         hi_ok         <= 1'b0;
         lo_ok         <= 1'b0;
         prescaler_out <= '0;
         period_out    <= '0;
         level_high    <= 1'b0;
         meas_valid    <= 1'b0;
         timeout       <= 1'b0;
`ifdef SQW_MATCH_EN
         match         <= 1'b0;
`endif
      end else begin
         // The synchronizer keeps running while idle so re-arming never sees a stale edge.
         s1         <= sig;
         s2         <= s1;
         s3         <= s2;
         meas_valid <= 1'b0;
         if (!ena) begin
            state         <= IDLE;
            cnt           <= '0;
            hi_cnt        <= '0;
            lo_cnt        <= '0;
            hi_ok         <= 1'b0;
            lo_ok         <= 1'b0;
            prescaler_out <= '0;
            period_out    <= '0;
            level_high    <= 1'b0;
            timeout       <= 1'b0;
`ifdef SQW_MATCH_EN
            match         <= 1'b0;
`endif
         end else begin
            case (state)
               IDLE: state <= ARM;
               ARM, RUN: begin
                  if (sig_edge) begin
                     cnt     <= '0;
                     timeout <= 1'b0;
                     if (state == ARM) begin
                        state <= RUN;
                     end else begin
                        prescaler_out <= cnt;
                        level_high    <= s3;
                        meas_valid    <= 1'b1;
                        period_out    <= other_ok ? period_sum : '0;
                        if (s3) begin
                           hi_cnt <= cnt;
                           hi_ok  <= 1'b1;
                        end else begin
                           lo_cnt <= cnt;
                           lo_ok  <= 1'b1;
                        end
`ifdef SQW_MATCH_EN
                        match <= match_hit;
`endif
                     end
                  end else begin
                     cnt <= cnt_inc;
                     if (cnt_inc >= TO_LIM) begin
                        timeout <= 1'b1;
`ifdef SQW_MATCH_EN
                        match   <= 1'b0;
`endif
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_square_wave_meter.sv
// Bench for square_wave_meter: sig transitions are driven at negedges; a model computes each
// half-period from transition times and queues the expected report for the monitor.
module tb_square_wave_meter;

   localparam int CNT_W     = 8;
   localparam int TIMEOUT   = 100;
   localparam int MATCH_TOL = 1;
   localparam int MAXC      = (1 << CNT_W) - 1;
   localparam int W         = 1 + (CNT_W + 1) + 1 + CNT_W;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             ena = 1'b0;
   logic             sig = 1'b0;
   logic [CNT_W-1:0] prescaler_out;
   logic [CNT_W:0]   period_out;
   logic             level_high;
   logic             meas_valid;
   logic             timeout;
   int               exp_val = 10;
`ifdef SQW_MATCH_EN
   logic [CNT_W-1:0] expected;
   logic             match;
   assign expected = CNT_W'(exp_val);
`endif

   square_wave_meter #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MATCH_TOL(MATCH_TOL)) dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .sig(sig),
      .prescaler_out(prescaler_out), .period_out(period_out), .level_high(level_high),
      .meas_valid(meas_valid), .timeout(timeout)
`ifdef SQW_MATCH_EN
      , .expected(expected), .match(match)
`endif
   );

   // clock / reset
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int tests = 0;
   int fails = 0;

   // scoreboard: {match, period, level, prescaler} plus the cycle it must appear in
   logic [W-1:0] exp_q[$];
   int           cyc_q[$];

   // reference model state
   bit model_on   = 0;
   bit seen_first = 0;
   int last_t     = 0;
   int half_len[2];
   bit half_ok[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic model_arm();
      seen_first = 0;
      half_ok[0] = 0;
      half_ok[1] = 0;
      model_on   = 1;
   endtask

   // driver: toggle sig now (at a negedge) and predict the report for the phase just ended
   task automatic toggle_sig();
      int g, p, per, d, li;
      bit m;
      li = sig ? 1 : 0;
      g = cyc - last_t;
      last_t = cyc;
      sig = ~sig;
      if (model_on) begin
         if (!seen_first) begin
            seen_first = 1;
         end else begin
            p = (g - 1 > MAXC) ? MAXC : g - 1;
            half_len[li] = p;
            half_ok[li]  = 1;
            per = half_ok[1-li] ? (p + half_len[1-li] + 2) % (1 << (CNT_W + 1)) : 0;
            d = p - exp_val;
            if (d < 0) d = -d;
            m = 0;
`ifdef SQW_MATCH_EN
            m = (d <= MATCH_TOL);
`endif
            exp_q.push_back({m, (CNT_W+1)'(per), li[0], CNT_W'(p)});
            cyc_q.push_back(cyc + 3);
         end
      end
   endtask

   task automatic half(input int n);
      toggle_sig();
      repeat (n) @(negedge clk);
   endtask

   task automatic arm();
      ena = 1'b1;
      model_arm();
      repeat (5) @(negedge clk);
   endtask

   task automatic disarm();
      ena = 1'b0;
      model_on = 0;
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_presc"}, 32'(prescaler_out), 0);
      check({tag, "_period"}, 32'(period_out), 0);
      check({tag, "_level"}, 32'(level_high), 0);
      check({tag, "_valid"}, 32'(meas_valid), 0);
      check({tag, "_timeout"}, 32'(timeout), 0);
`ifdef SQW_MATCH_EN
      check({tag, "_match"}, 32'(match), 0);
`endif
   endtask

   // monitor
   logic [W-1:0] e;
   int           ec;
   logic         ma;
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && meas_valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_meas", 32'(prescaler_out), 32'hFFFF_FFFF);
            end else begin
               e  = exp_q.pop_front();
               ec = cyc_q.pop_front();
               check("meas_latency", 32'(cyc), 32'(ec));
               check("meas_presc", 32'(prescaler_out), 32'(e[CNT_W-1:0]));
               check("meas_level", 32'(level_high), 32'(e[CNT_W]));
               check("meas_period", 32'(period_out), 32'(e[2*CNT_W+1:CNT_W+1]));
               check("meas_timeout_clear", 32'(timeout), 0);
               ma = 1'b0;
`ifdef SQW_MATCH_EN
               ma = match;
               check("meas_match", 32'(ma), 32'(e[W-1]));
`endif
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   int t0;
   initial begin
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("idle");

      // generator P=4, then P=0, then asymmetric high 7 / low 3
      exp_val = 4;
      arm();
      repeat (8) half(5);
      repeat (8) half(1);
      repeat (8) begin
         toggle_sig();
         repeat (sig ? 7 : 3) @(negedge clk);
      end

      // match boundary: measured 11 and 12 against expected 10
      repeat (5) @(negedge clk);
      exp_val = 10;
      repeat (3) begin
         half(12);
         half(13);
      end

      // random half-periods
      repeat (5) @(negedge clk);
      exp_val = $urandom_range(0, 20);
      repeat (40) half($urandom_range(1, 40));

      // async reset mid-run, with sig left low so the synchronizer sees no edge on release
      if (sig) half(6);
      else begin
         half(6);
         half(6);
      end
      #2 rst_n = 1'b0;
      #1 check_all_zero("async_rst");
      @(negedge clk);
      rst_n = 1'b1;
      model_arm();
      repeat (5) @(negedge clk);
      exp_val = $urandom_range(0, 20);
      repeat (20) half($urandom_range(1, 25));

      // ena low mid-half with P=20
      half(21);
      half(21);
      toggle_sig();
      repeat (10) @(negedge clk);
      disarm();
      check_all_zero("ena_low");
      repeat (5) @(negedge clk);
      arm();
      half(21);
      half(21);
      toggle_sig();
      repeat (5) @(negedge clk);

      // timeout in ARM, then in RUN with a saturating half
      exp_val = 10;
      disarm();
      repeat (5) @(negedge clk);
      ena = 1'b1;
      model_arm();
      repeat (TIMEOUT) @(negedge clk);
      check("to_arm_early", 32'(timeout), 0);
      @(negedge clk);
      check("to_arm_set", 32'(timeout), 1);
      repeat (20) @(negedge clk);
      check("to_arm_sticky", 32'(timeout), 1);
      toggle_sig();
      repeat (2) @(negedge clk);
      check("to_arm_before_edge", 32'(timeout), 1);
      @(negedge clk);
      check("to_arm_cleared", 32'(timeout), 0);
      repeat (8) @(negedge clk);
      toggle_sig();
      t0 = cyc;
      repeat (TIMEOUT + 2) @(negedge clk);
      check("to_run_early", 32'(timeout), 0);
      @(negedge clk);
      check("to_run_set", 32'(timeout), 1);
`ifdef SQW_MATCH_EN
      check("to_run_match_clr", 32'(match), 0);
`endif
      repeat (300 - (cyc - t0)) @(negedge clk);
      toggle_sig();
      repeat (7) @(negedge clk);
      toggle_sig();
      repeat (10) @(negedge clk);

      check("queue_drained", 32'(exp_q.size()), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
